// File: rtl/z_writeback.sv
// Writeback stage: captures the 64-bit ALU C result, emits LO-side results onto the bus
// and commits mul/div results to HI/LO. Optional flag outputs are enabled by ZWB_FLAGS_EN.
module z_writeback #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [2*DATA_W-1:0]   c_in,
  input  logic [4:0]            opcode,
  input  logic                  cap_valid,
  output logic                  cap_ready,
  output logic [DATA_W-1:0]     bus_out,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [DATA_W-1:0]     hi_out,
  output logic [DATA_W-1:0]     lo_out,
  output logic                  busy
`ifdef ZWB_FLAGS_EN
  ,
  output logic                  z_flag,
  output logic                  n_flag
`endif
);

  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    WRITE_HL
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [DATA_W-1:0]   z_hi;
  logic [DATA_W-1:0]   z_lo;
  logic [4:0]          op_q;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;

  logic                capture;
  logic                in_is_hl;
  logic                in_is_mfhi;
  logic                in_is_mflo;
  logic                q_is_hl;
  logic                hl_write;
  logic [DATA_W-1:0]   capture_lo;
  logic [DATA_W-1:0]   capture_hi;

  assign in_is_hl   = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign in_is_mfhi = (opcode == OP_MFHI);
  assign in_is_mflo = (opcode == OP_MFLO);
  assign q_is_hl    = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign capture    = cap_valid && (state == IDLE);

  // mfhi/mflo read the live HI/LO, so a move right after WRITE_HL sees the fresh value.
  always_comb begin
    capture_lo = c_in[DATA_W-1:0];
    capture_hi = c_in[2*DATA_W-1:DATA_W];
    if (in_is_mfhi) begin
      capture_lo = hi;
      capture_hi = '0;
    end else if (in_is_mflo) begin
      capture_lo = lo;
      capture_hi = '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (capture) begin
          state_next = in_is_hl ? WRITE_HL : EMIT;
        end
      end
      EMIT: begin
        if (bus_ready) begin
          state_next = IDLE;
        end
      end
      WRITE_HL: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    cap_ready = 1'b0;
    bus_valid = 1'b0;
    bus_out   = '0;
    busy      = 1'b1;
    hl_write  = 1'b0;
    case (state)
      IDLE: begin
        cap_ready = 1'b1;
        busy      = 1'b0;
      end
      EMIT: begin
        bus_valid = 1'b1;
        bus_out   = z_lo;
      end
      WRITE_HL: begin
        hl_write  = q_is_hl;
      end
      default: begin
        busy      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      z_hi <= '0;
      z_lo <= '0;
      op_q <= '0;
    end else if (capture) begin
      z_hi <= capture_hi;
      z_lo <= capture_lo;
      op_q <= opcode;
    end
  end

  // For div the ALU places the remainder in the upper half and the quotient in the lower half.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hi <= '0;
      lo <= '0;
    end else if (hl_write) begin
      hi <= z_hi;
      lo <= z_lo;
    end
  end

  assign hi_out = hi;
  assign lo_out = lo;

`ifdef ZWB_FLAGS_EN
  // mul/div flags span the full 64-bit product; everything else reflects the emitted word.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      z_flag <= 1'b0;
      n_flag <= 1'b0;
    end else if (capture) begin
      if (in_is_hl) begin
        z_flag <= (c_in == '0);
        n_flag <= c_in[2*DATA_W-1];
      end else begin
        z_flag <= (capture_lo == '0);
        n_flag <= capture_lo[DATA_W-1];
      end
    end
  end
`endif

endmodule

// File: tb/tb_z_writeback.sv
// Directed bench for z_writeback: table of single-instruction vectors plus
// hand-written backpressure and reset-abort sequences. Flags are checked when ZWB_FLAGS_EN is set.
module tb_z_writeback;

  logic        clk;
  logic        clr;
  logic [63:0] c_in;
  logic [4:0]  opcode;
  logic        cap_valid;
  logic        cap_ready;
  logic [31:0] bus_out;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
`ifdef ZWB_FLAGS_EN
  logic        z_flag;
  logic        n_flag;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int xfer_count  = 0;

  z_writeback #(.DATA_W(32)) dut (
    .clk       (clk),
    .clr       (clr),
    .c_in      (c_in),
    .opcode    (opcode),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy      (busy)
`ifdef ZWB_FLAGS_EN
    ,
    .z_flag    (z_flag),
    .n_flag    (n_flag)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (clr && bus_valid && bus_ready) xfer_count++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got no completion, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [4:0]  op;
    logic [63:0] c;
    logic        emit;
    logic [31:0] exp_bus;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_z;
    logic        exp_n;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string what, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, actual, expected);
    end
  endtask

  // Present one capture for a single edge; returns #1 after that edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [63:0] c);
    cap_valid = 1'b1;
    opcode    = op;
    c_in      = c;
    @(posedge clk);
    #1;
    cap_valid = 1'b0;
    c_in      = 64'h0;
  endtask

  task automatic checkFlags(input string tag, input logic ez, input logic en);
`ifdef ZWB_FLAGS_EN
    checkOutput({tag, " z_flag"}, z_flag, ez);
    checkOutput({tag, " n_flag"}, n_flag, en);
`else
    if (ez === 1'bz && en === 1'bz) $display("[TB] flags disabled");
`endif
  endtask

  initial begin
    int base;

    vecs[0]  = '{5'b00011, 64'h0000_0000_0000_0007, 1'b1, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1]  = '{5'b01111, 64'h0000_0001_FFFF_FFFE, 1'b0, 32'h0,         32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2]  = '{5'b11000, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3]  = '{5'b11001, 64'h1111_2222_3333_4444, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b1};
    vecs[4]  = '{5'b00100, 64'h1234_5678_FFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b1};
    vecs[5]  = '{5'b10000, 64'h0000_0003_0000_0005, 1'b0, 32'h0,         32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0};
    vecs[6]  = '{5'b11001, 64'h0,                   1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0};
    vecs[7]  = '{5'b01111, 64'h0,                   1'b0, 32'h0,         32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8]  = '{5'b11000, 64'h5555_5555_5555_5555, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{5'b10000, 64'h8000_0000_0000_0001, 1'b0, 32'h0,         32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1};
    vecs[10] = '{5'b00011, 64'hFFFF_FFFF_0000_0000, 1'b1, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0};

    clr       = 1'b0;
    c_in      = 64'h0;
    opcode    = 5'b0;
    cap_valid = 1'b0;
    bus_ready = 1'b0;

    #12;
    checkOutput("reset bus_valid", bus_valid, 0);
    checkOutput("reset bus_out", bus_out, 0);
    checkOutput("reset hi_out", hi_out, 0);
    checkOutput("reset lo_out", lo_out, 0);
    checkOutput("reset busy", busy, 0);
    checkFlags("reset", 1'b0, 1'b0);

    @(posedge clk);
    #1;
    clr = 1'b1;
    checkOutput("post-reset cap_ready", cap_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      bus_ready = 1'b1;
      applyStimulus(vecs[i].op, vecs[i].c);
      checkOutput($sformatf("v%0d busy", i), busy, 1);
      checkOutput($sformatf("v%0d cap_ready busy", i), cap_ready, 0);
      if (vecs[i].emit) begin
        checkOutput($sformatf("v%0d bus_valid", i), bus_valid, 1);
        checkOutput($sformatf("v%0d bus_out", i), bus_out, vecs[i].exp_bus);
      end else begin
        checkOutput($sformatf("v%0d bus_valid hl", i), bus_valid, 0);
        checkOutput($sformatf("v%0d bus_out hl", i), bus_out, 0);
      end
      checkFlags($sformatf("v%0d", i), vecs[i].exp_z, vecs[i].exp_n);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d idle bus_valid", i), bus_valid, 0);
      checkOutput($sformatf("v%0d idle bus_out", i), bus_out, 0);
      checkOutput($sformatf("v%0d idle cap_ready", i), cap_ready, 1);
      checkOutput($sformatf("v%0d hi_out", i), hi_out, vecs[i].exp_hi);
      checkOutput($sformatf("v%0d lo_out", i), lo_out, vecs[i].exp_lo);
    end

    // Backpressure: five stalled cycles, an ignored capture attempt, then one transfer.
    bus_ready = 1'b0;
    base = xfer_count;
    applyStimulus(5'b00011, 64'h0000_0000_0BAD_F00D);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall%0d bus_valid", k), bus_valid, 1);
      checkOutput($sformatf("stall%0d bus_out", k), bus_out, 32'h0BAD_F00D);
      checkOutput($sformatf("stall%0d cap_ready", k), cap_ready, 0);
      if (k == 1) begin
        cap_valid = 1'b1;
        opcode    = 5'b01111;
        c_in      = 64'h0123_4567_89AB_CDEF;
      end
      @(posedge clk);
      #1;
      cap_valid = 1'b0;
      c_in      = 64'h0;
    end
    checkOutput("stall hi untouched", hi_out, 32'h8000_0000);
    bus_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release bus_valid", bus_valid, 0);
    checkOutput("release cap_ready", cap_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("release bus_valid again", bus_valid, 0);
    checkOutput("release busy", busy, 0);
    checkOutput("transfer count", xfer_count - base, 1);
    checkOutput("release hi_out", hi_out, 32'h8000_0000);
    checkOutput("release lo_out", lo_out, 32'h0000_0001);

    // Reset during WRITE_HL of a div aborts the write and clears HI/LO at once.
    applyStimulus(5'b10000, 64'h0000_0003_0000_0005);
    checkOutput("div busy", busy, 1);
    #2;
    clr = 1'b0;
    #1;
    checkOutput("abort hi_out", hi_out, 0);
    checkOutput("abort lo_out", lo_out, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort cap_ready", cap_ready, 1);
    checkFlags("abort", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    checkOutput("after abort cap_ready", cap_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("after abort hi_out", hi_out, 0);
    checkOutput("after abort lo_out", lo_out, 0);

    // Reset during EMIT drops the pending bus result.
    bus_ready = 1'b0;
    applyStimulus(5'b00011, 64'h0000_0000_0000_0055);
    checkOutput("emit pre-abort bus_out", bus_out, 32'h55);
    #2;
    clr = 1'b0;
    #1;
    checkOutput("emit abort bus_valid", bus_valid, 0);
    checkOutput("emit abort bus_out", bus_out, 0);
    @(posedge clk);
    #1;
    clr       = 1'b1;
    bus_ready = 1'b1;
    checkOutput("emit abort busy", busy, 0);

    applyStimulus(5'b11000, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("mfhi after reset bus_out", bus_out, 0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/z_writeback.md
Z_WRITEBACK -- requirements
Module: z_writeback

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 32, the bus word width (C input is 2*DATA_W).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port c_in, input, 64 bits: the ALU C result.
REQ-005 The block SHALL have port opcode, input, 5 bits: the opcode of the instruction producing c_in.
REQ-006 The block SHALL have ports cap_valid (input, 1 bit) and cap_ready (output, 1 bit): the capture handshake.
REQ-007 The block SHALL have ports bus_out (output, 32 bits), bus_valid (output, 1 bit) and bus_ready (input, 1 bit): the result-to-bus handshake.
REQ-008 The block SHALL have ports hi_out and lo_out, outputs, 32 bits each: the architectural HI and LO registers.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 The block SHALL implement FSM states IDLE, EMIT and WRITE_HL.
REQ-011 cap_ready SHALL be 1 only in IDLE; a capture occurs on an edge where cap_valid=1 and cap_ready=1.
REQ-012 On capture, the block SHALL register z_hi=c_in[63:32], z_lo=c_in[31:0] and opcode.
REQ-013 On capture with opcode 01111 (mul) or 10000 (div), the FSM SHALL go to WRITE_HL.
REQ-014 In WRITE_HL, the block SHALL load hi<=z_hi and lo<=z_lo (div: HI=remainder, LO=quotient), keep bus_valid=0, and return to IDLE after exactly 1 cycle.
REQ-015 On capture with opcode 11000 (mfhi) or 11001 (mflo), the block SHALL ignore c_in, load z_lo from the current hi or lo respectively, and go to EMIT.
REQ-016 On capture with any other opcode, the FSM SHALL go to EMIT.
REQ-017 In EMIT, bus_valid SHALL be 1 and bus_out SHALL equal z_lo, held stable until bus_ready=1.
REQ-018 On an EMIT edge with bus_ready=1, the FSM SHALL return to IDLE; bus_valid SHALL be 0 in the following cycle.
REQ-019 Latency SHALL be: capture at edge N gives bus_valid=1 in cycle N+1; a new capture is accepted no earlier than one cycle after the bus handshake.
REQ-020 cap_valid asserted outside IDLE SHALL be ignored with no state change; the upstream holds it.
REQ-021 When the state is not EMIT, bus_out SHALL be 0.
REQ-022 A mfhi/mflo captured in the IDLE cycle immediately after WRITE_HL SHALL return the newly written HI/LO value.

Reset
REQ-023 While clr=0, the block SHALL immediately force state IDLE, and set bus_valid=0, bus_out=0, hi_out=0, lo_out=0, busy=0, and clear z_hi, z_lo and the stored opcode.
REQ-024 After clr rises, cap_ready SHALL be 1 in the first cycle.
REQ-025 A reset asserted mid-EMIT or mid-WRITE_HL SHALL abort the operation without updating HI/LO.

Configuration
REQ-026 With macro ZWB_FLAGS_EN defined, the block SHALL add output ports z_flag and n_flag (1 bit each), registered at capture.
REQ-027 With ZWB_FLAGS_EN, for mul/div the flags SHALL be z=(c_in==0) over all 64 bits and n=c_in[63].
REQ-028 With ZWB_FLAGS_EN, for all other opcodes the flags SHALL be computed on the emitted 32-bit value: z=(value==0), n=value[31].
REQ-029 With ZWB_FLAGS_EN, reset SHALL clear both flags.
REQ-030 Without ZWB_FLAGS_EN, the flag ports and flag logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-031 The bench SHALL cover add: opcode 00011, c_in=0x0000_0000_0000_0007, bus_ready=1 -> bus_valid=1 with bus_out=0x7 one cycle after capture, then IDLE.
REQ-032 The bench SHALL cover mul then mfhi: mul capture with c_in=0x0000_0001_FFFF_FFFE -> after 1 cycle hi_out=0x1 and lo_out=0xFFFFFFFE with no bus_valid; the next mfhi emits 0x1.
REQ-033 The bench SHALL cover backpressure: bus_ready=0 for 5 cycles in EMIT -> bus_out stable, cap_ready=0, and a cap_valid pulse is ignored; bus_ready=1 -> exactly one transfer.
REQ-034 The bench SHALL cover reset mid-operation: clr=0 during WRITE_HL of div c_in=0x3_0000_0005 -> hi_out=lo_out=0 immediately, state IDLE.
REQ-035 The bench SHALL cover flags (ZWB_FLAGS_EN): sub result 0xFFFF_FFFF -> n=1, z=0; mul c_in=0 -> z=1, n=0.
